pwm_decoder: RTL



---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_sync.sv | 23 ++
 rtl/pwm_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the PWM decoder
package pwm_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_t;

    function automatic int unsigned timeout_cycles(input int unsigned width);
        return (32'd1 << (width + 1)) - 32'd1;
    endfunction

    // Clamp a measured count to the largest value a width-bit level can hold.
    function automatic logic [31:0] sat_level(input logic [32:0] cnt, input int unsigned width);
        logic [32:0] lim;
        lim = (33'd1 << width) - 33'd1;
        return (cnt > lim) ? lim[31:0] : cnt[31:0];
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// rtl/pwm_sync.sv - multi-flop synchronizer with synchronous reset
module pwm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM level/period decoder; PWM_DECODER_GLITCH_FILTER_EN adds a 2-cycle deglitcher
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int INVERT      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH:0]   period,
    output logic             valid,
    output logic             stuck
);

    localparam int unsigned    TO_INT  = timeout_cycles(WIDTH);
    localparam logic [WIDTH:0] TIMEOUT = TO_INT[WIDTH:0];
    localparam logic           INV     = (INVERT != 0);

    logic s;
    logic filt;
    logic a;
    logic a_prev;
    logic rise;
    logic tmo;

    pwm_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pwm_in),
        .q     (s)
    );

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic s_q;
    logic filt_q;

    // Accept a new value only once it has been seen on two consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            s_q <= s;
            if (s == s_q) begin
                filt_q <= s;
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = s;
`endif

    assign a = filt ^ INV;

    // a_prev resets to the idle active value so an inverted line gives no spurious rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_prev <= INV;
        end else begin
            a_prev <= a;
        end
    end

    assign rise = a & ~a_prev;

    state_t           state, state_d;
    logic [WIDTH:0]   hi_cnt, hi_cnt_d;
    logic [WIDTH:0]   per_cnt, per_cnt_d;
    logic [WIDTH:0]   idle_cnt, idle_cnt_d;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH:0]   period_d;
    logic             valid_d;
    logic             stuck_d;

    // In SEEK the idle counter stops once stuck, so only one timeout strobe is produced.
    assign tmo = (state == MEAS) ? (per_cnt == TIMEOUT)
                                 : (!stuck && (idle_cnt == TIMEOUT - 1'b1));

    always_comb begin
        state_d    = state;
        hi_cnt_d   = hi_cnt;
        per_cnt_d  = per_cnt;
        idle_cnt_d = idle_cnt;
        level_d    = level;
        period_d   = period;
        valid_d    = 1'b0;
        stuck_d    = stuck;

        if (rise) begin
            if (state == MEAS) begin
                level_d  = WIDTH'(sat_level(33'(hi_cnt), WIDTH));
                period_d = per_cnt;
                valid_d  = 1'b1;
            end
            state_d    = MEAS;
            stuck_d    = 1'b0;
            hi_cnt_d   = 1;
            per_cnt_d  = 1;
            idle_cnt_d = '0;
        end else if (tmo) begin
            level_d    = a ? '1 : '0;
            period_d   = '1;
            valid_d    = 1'b1;
            stuck_d    = 1'b1;
            state_d    = SEEK;
            hi_cnt_d   = '0;
            per_cnt_d  = '0;
            idle_cnt_d = '0;
        end else if (state == MEAS) begin
            per_cnt_d = per_cnt + 1'b1;
            if (a) begin
                hi_cnt_d = hi_cnt + 1'b1;
            end
        end else if (!stuck) begin
            idle_cnt_d = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEEK;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
            level    <= '0;
            period   <= '0;
            valid    <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            state    <= state_d;
            hi_cnt   <= hi_cnt_d;
            per_cnt  <= per_cnt_d;
            idle_cnt <= idle_cnt_d;
            level    <= level_d;
            period   <= period_d;
            valid    <= valid_d;
            stuck    <= stuck_d;
        end
    end

endmodule
